// File: rtl/jpeg_stream_arbiter_if.sv
// Handshake bundle between the two JPEG requesters, the arbiter and jpeg_core.
// slave is the arbiter's view; master is the surrounding system's view.
interface jpeg_stream_arbiter_if #(
  parameter int PIX_W = 88
);
  logic [1:0]       req_valid_i;
  logic [63:0]      req_data_i;
  logic [7:0]       req_strb_i;
  logic [1:0]       req_last_i;
  logic [1:0]       req_accept_o;
  logic             core_valid_o;
  logic [31:0]      core_data_o;
  logic [3:0]       core_strb_o;
  logic             core_last_o;
  logic             core_accept_i;
  logic             core_idle_i;
  logic             core_pix_valid_i;
  logic [PIX_W-1:0] core_pix_data_i;
  logic             core_pix_accept_o;
  logic [1:0]       pix_valid_o;
  logic [PIX_W-1:0] pix_data_o;
  logic [1:0]       pix_accept_i;
  logic             owner_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_strb_i, req_last_i,
    output req_accept_o,
    output core_valid_o, core_data_o, core_strb_o, core_last_o,
    input  core_accept_i, core_idle_i, core_pix_valid_i, core_pix_data_i,
    output core_pix_accept_o, pix_valid_o, pix_data_o,
    input  pix_accept_i,
    output owner_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_strb_i, req_last_i,
    input  req_accept_o,
    input  core_valid_o, core_data_o, core_strb_o, core_last_o,
    output core_accept_i, core_idle_i, core_pix_valid_i, core_pix_data_i,
    input  core_pix_accept_o, pix_valid_o, pix_data_o,
    output pix_accept_i,
    input  owner_o, busy_o
  );
endinterface

// File: rtl/jpeg_stream_arbiter.sv
// Frame-locked round-robin arbiter sharing one jpeg_core between two byte-stream requesters.
// Define JPEG_STREAM_ARB_STATS_EN to add per-requester saturating frame counters on frame_cnt_o.
module jpeg_stream_arbiter #(
  parameter int DRAIN_GUARD = 4,
  parameter int PIX_W       = 88
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  jpeg_stream_arbiter_if.slave bus
`ifdef JPEG_STREAM_ARB_STATS_EN
  ,
  output logic [31:0]          frame_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  localparam int GW = (DRAIN_GUARD > 1) ? $clog2(DRAIN_GUARD) : 1;
  // DRAIN spans max(DRAIN_GUARD,1) cycles before idle can end it, so the counter loads one short.
  localparam logic [GW-1:0] GUARD_LOAD = (DRAIN_GUARD > 1) ? GW'(DRAIN_GUARD - 1) : '0;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [GW-1:0]    guard_q, guard_d;

  logic             lane_valid;
  logic [31:0]      lane_data;
  logic [3:0]       lane_strb;
  logic             lane_last;
  logic             streaming;
  logic             beat_xfer;
  logic             last_xfer;
  logic [PIX_W-1:0] pix_data;

  assign lane_valid = bus.req_valid_i[owner_q];
  assign lane_data  = owner_q ? bus.req_data_i[63:32] : bus.req_data_i[31:0];
  assign lane_strb  = owner_q ? bus.req_strb_i[7:4]   : bus.req_strb_i[3:0];
  assign lane_last  = bus.req_last_i[owner_q];
  assign streaming  = (state_q == S_STREAM);
  assign beat_xfer  = streaming & lane_valid & bus.core_accept_i;
  assign last_xfer  = beat_xfer & lane_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    guard_d = guard_q;
    case (state_q)
      S_IDLE: begin
        if (bus.core_idle_i && (|bus.req_valid_i)) begin
          owner_d = (&bus.req_valid_i) ? rr_q : bus.req_valid_i[1];
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_xfer) begin
          rr_d    = ~owner_q;
          guard_d = GUARD_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (guard_q != '0) begin
          guard_d = guard_q - 1'b1;
        end else if (bus.core_idle_i && !bus.core_pix_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.core_valid_o = streaming & lane_valid;
  assign bus.core_data_o  = streaming ? lane_data : 32'h0;
  assign bus.core_strb_o  = streaming ? lane_strb : 4'h0;
  assign bus.core_last_o  = streaming & lane_last;
  assign bus.req_accept_o = !streaming ? 2'b00 :
                            (owner_q ? {bus.core_accept_i, 1'b0} : {1'b0, bus.core_accept_i});

  // Pixels follow owner_q in every state so late pixels reach the previous owner; held low in reset.
  assign bus.pix_valid_o       = (rst_ni & bus.core_pix_valid_i) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.core_pix_accept_o = rst_ni & bus.pix_accept_i[owner_q];
  assign pix_data              = bus.core_pix_data_i;
  assign bus.pix_data_o        = pix_data;

  assign bus.owner_o = owner_q;
  assign bus.busy_o  = (state_q != S_IDLE);

`ifdef JPEG_STREAM_ARB_STATS_EN
  logic [15:0] cnt_q [2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q[0] <= 16'h0;
      cnt_q[1] <= 16'h0;
    end else if (last_xfer && (cnt_q[owner_q] != 16'hFFFF)) begin
      cnt_q[owner_q] <= cnt_q[owner_q] + 16'd1;
    end
  end

  assign frame_cnt_o = {cnt_q[1], cnt_q[0]};
`else
  // Statistics not built: no counters and no frame_cnt_o port.
`endif

endmodule
